// File: rtl/vga_pkg.sv
// Shared VGA frame buffer constants, colours and fill FSM states.
// Used by the rectangle fill engine and the scan-out stage.
package vga_pkg;

  localparam int H_RES   = 320;
  localparam int V_RES   = 240;
  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 3;
  localparam int ADDR_W  = 17;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t BLACK   = 3'd0;
  localparam color_t RED     = 3'd1;
  localparam color_t GREEN   = 3'd2;
  localparam color_t YELLOW  = 3'd3;
  localparam color_t BLUE    = 3'd4;
  localparam color_t MAGENTA = 3'd5;
  localparam color_t CYAN    = 3'd6;
  localparam color_t WHITE   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } fill_state_t;

endpackage

// File: rtl/vram_rect_walker.sv
// Raster walker over a clipped rectangle: x, y and row base address.
// Advances one pixel per retired write and flags the final pixel.
module vram_rect_walker
  import vga_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [X_W-1:0]    x0,
  input  logic [X_W-1:0]    x_end,
  input  logic [Y_W-1:0]    y0,
  input  logic [Y_W-1:0]    y_end,
  input  logic [ADDR_W-1:0] base0,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [X_W-1:0]    X_ONE    = X_W'(1);
  localparam logic [Y_W-1:0]    Y_ONE    = Y_W'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  logic [X_W-1:0]    x_lo;
  logic [X_W-1:0]    x_hi;
  logic [Y_W-1:0]    y_hi;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ADDR_W-1:0] row_base;
  logic [X_W-1:0]    x_nxt;
  logic [Y_W-1:0]    y_nxt;
  logic              row_end;

  // next-position arithmetic and last-pixel flag
  always_comb begin
    x_nxt   = x + X_ONE;
    y_nxt   = y + Y_ONE;
    row_end = (x_nxt == x_hi);
    last    = row_end && (y_nxt == y_hi);
    addr    = row_base + {{(ADDR_W-X_W){1'b0}}, x};
  end

  // load rectangle bounds, then step in raster order on each retire
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_lo     <= '0;
      x_hi     <= '0;
      y_hi     <= '0;
      x        <= '0;
      y        <= '0;
      row_base <= '0;
    end else if (load) begin
      x_lo     <= x0;
      x_hi     <= x_end;
      y_hi     <= y_end;
      x        <= x0;
      y        <= y0;
      row_base <= base0;
    end else if (step) begin
      if (row_end) begin
        x        <= x_lo;
        y        <= y_nxt;
        row_base <= row_base + ROW_STEP;
      end else begin
        x        <= x_nxt;
      end
    end
  end

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: accepts a command, clips it to the screen
// and streams one pixel write per cycle into the frame buffer.
module vram_rect_fill
  import vga_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  input  logic               wr_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES);
  localparam logic [X_W:0]   X_LIM = {1'b0, X_MAX};
  localparam logic [Y_W:0]   Y_LIM = {1'b0, Y_MAX};

  fill_state_t        state;
  fill_state_t        state_nxt;
  logic               up_q;
  color_t             color_q;
  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;
  logic [X_W-1:0]     x_end;
  logic [Y_W-1:0]     y_end;
  logic [ADDR_W-1:0]  base0;
  logic               degen;
  logic               accept;
  logic               step;
  logic               last;
  logic [ADDR_W-1:0]  walk_addr;

  // clip bounds and first row base (y*320 as two shifts)
  always_comb begin
    x_sum  = {1'b0, cmd_x0} + {1'b0, cmd_w};
    y_sum  = {1'b0, cmd_y0} + {1'b0, cmd_h};
    x_end  = (x_sum > X_LIM) ? X_MAX : x_sum[X_W-1:0];
    y_end  = (y_sum > Y_LIM) ? Y_MAX : y_sum[Y_W-1:0];
    base0  = {{(ADDR_W-Y_W-8){1'b0}}, cmd_y0, 8'b0}
           + {{(ADDR_W-Y_W-6){1'b0}}, cmd_y0, 6'b0};
    degen  = (cmd_w == '0) || (cmd_h == '0)
          || (cmd_x0 >= X_MAX) || (cmd_y0 >= Y_MAX);
    accept = cmd_valid && up_q && (state == S_IDLE);
    step   = (state == S_FILL) && wr_ready;
  end

  // state, post-reset ready flag and latched colour
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      up_q    <= 1'b0;
      color_q <= BLACK;
    end else begin
      state   <= state_nxt;
      up_q    <= 1'b1;
      if (accept) color_q <= cmd_color;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = up_q;
        busy      = 1'b0;
        if (accept) state_nxt = degen ? S_DONE : S_FILL;
      end
      S_FILL: begin
        wr_en = 1'b1;
        if (step && last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign wr_addr = walk_addr;
  assign wr_data = color_q;

  vram_rect_walker u_walker (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (accept && !degen),
    .step    (step),
    .x0      (cmd_x0),
    .x_end   (x_end),
    .y0      (cmd_y0),
    .y_end   (y_end),
    .base0   (base0),
    .addr    (walk_addr),
    .last    (last)
  );

endmodule
